mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter between the instruction cache and the data cache of the pipelined LC-3b core. It shares the single physical-memory line interface between the two caches and serialises their line fills and write-backs. Grants go round-robin on contention. Each transaction's address, data and opcode are registered at grant, so the physical memory sees stable inputs for the whole access.

## Interface
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- LINE_WIDTH, 128, cache line width in bits
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registered state
- i_read  in  1  icache line read request, held until i_resp
- i_address  in  ADDR_WIDTH  icache line address
- i_rdata  out  LINE_WIDTH  line data to icache (valid only with i_resp)
- i_resp  out  1  icache transaction complete, one-cycle pulse
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line write request, held until d_resp
- d_address  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache write-back line
- d_rdata  out  LINE_WIDTH  line data to dcache (valid only with d_resp)
- d_resp  out  1  dcache transaction complete, one-cycle pulse
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_address  out  ADDR_WIDTH  registered transaction address
- pmem_wdata  out  LINE_WIDTH  registered write data
- pmem_rdata  in  LINE_WIDTH  physical memory read data
- pmem_resp  in  1  physical memory access complete
- arb_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE with only the icache requesting:
  - goes to SERVE_I.
  - Latches i_address into addr_q and op_q=read.
- IDLE with only the dcache requesting:
  - goes to SERVE_D.
  - Latches d_address and d_wdata.
  - op_q=write if d_write, else read.
  - d_read and d_write both high is treated as a write.
- IDLE with both requesting:
  - grants the port that lost the previous contested arbitration.
  - last_winner resets to I, so the first tie goes to D.
  - last_winner updates only on contested grants.
- SERVE_x:
  - pmem_read=(op_q==read), pmem_write=(op_q==write).
  - pmem_address=addr_q, pmem_wdata=wdata_q.
  - Requester inputs are ignored after grant.
- SERVE_x with pmem_resp=1:
  - x_resp=1 combinationally in the same cycle.
  - Next state DONE.
- DONE:
  - strobes low, no resp.
  - Unconditionally returns to IDLE. This gives the requester one cycle to drop its request.
- i_rdata and d_rdata are both a direct passthrough of pmem_rdata. Consumers qualify them with their own resp.
- Request dropped mid-service: the transaction still completes and the resp still pulses. This is a protocol violation but must not hang the block.
- pmem_resp while in IDLE or DONE is ignored.
- Reset at any time, including mid-SERVE:
  - immediately drives pmem_read/pmem_write/i_resp/d_resp/arb_busy to 0.
  - state=IDLE, addr_q=0, wdata_q=0, op_q=read, last_winner=I.
  - The interrupted transaction is dropped, with no resp.

## Timing
- Reset values: all strobes, resps and arb_busy 0; pmem_address 0; pmem_wdata 0.
- Request sampled in IDLE at cycle 0: state=SERVE and pmem strobe high at cycle 1.
- pmem_resp at cycle k: x_resp at cycle k, DONE at k+1, IDLE at k+2. The earliest next strobe is at k+3.
- Minimum occupancy per transaction with a one-cycle memory: 4 cycles (IDLE, SERVE, DONE, back to IDLE).
- pmem_address, pmem_wdata and the strobes never change while in SERVE. They are glitch-free relative to requester input changes.
- Exactly one resp pulse per granted transaction. i_resp and d_resp are never high together.

## Test plan
- Reset then idle: hold reset 3 cycles and release with no requests.
  - All outputs stay 0 for 10 cycles.
- Single icache read:
  - Stimulus: i_read=1, i_address=0x1230; memory responds 2 cycles after the strobe with pmem_rdata=128'hA5...A5.
  - pmem_read is high for exactly 3 cycles with address 0x1230.
  - i_resp pulses once with i_rdata=A5...A5. d_resp stays 0.
- Dcache write-back:
  - Stimulus: d_write=1, d_address=0x4000, d_wdata=128'h0123...CDEF.
  - pmem_write=1 with matching address and data. pmem_read=0 throughout. d_resp pulses once.
- Contention out of reset:
  - Stimulus: i_read and d_read rise in the same cycle and are held until each resp.
  - D is served first, then I.
  - A second simultaneous pair then serves I first (round-robin alternation).
- Input change during service:
  - Stimulus: change d_address from 0x4000 to 0x5000 one cycle after the grant.
  - pmem_address stays 0x4000 until d_resp.
- Reset mid-transaction:
  - Stimulus: assert reset during SERVE_I before pmem_resp.
  - pmem_read drops in the same cycle and no i_resp is issued.
  - After release with i_read still held, a fresh grant occurs on the next IDLE sample.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : shares one physical-memory line port between the icache and the dcache, round-robin on contention.
// Latency : grant one cycle after a request is seen in IDLE; resp in the same cycle as pmem_resp; two recovery cycles before the next grant.
// Backpressure: requests are held by the caches until their resp; a losing port simply waits in IDLE for the next sample.
//
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   i_read/i_address         - icache line read request (held until i_resp)
//   i_rdata/i_resp           - icache line data (qualified by i_resp) and completion pulse
//   d_read/d_write/d_address - dcache line request (held until d_resp); read+write counts as write
//   d_wdata                  - dcache write-back line
//   d_rdata/d_resp           - dcache line data (qualified by d_resp) and completion pulse
//   pmem_*                   - physical memory strobes, registered address/data, returned data and completion
//   arb_busy                 - high whenever a transaction is in flight or recovering
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  arb_busy
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
   // The strobe flops carry the transaction opcode: exactly one is set for the whole SERVE phase.
   logic                    rd_q, rd_d;
   logic                    wr_q, wr_d;
   logic                    busy_q, busy_d;
   // 1 = dcache won the most recent contested arbitration.
   logic                    last_d_q, last_d_d;

   logic                    i_req, d_req, grant_i, grant_d;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      busy_d   = busy_q;
      last_d_d = last_d_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req && d_req) begin
               // Serve whoever lost last time; only contested grants move the pointer.
               grant_d  = ~last_d_q;
               grant_i  = last_d_q;
               last_d_d = ~last_d_q;
            end else begin
               grant_i = i_req;
               grant_d = d_req;
            end

            if (grant_i) begin
               state_d = SERVE_I;
               addr_d  = i_address;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               busy_d  = 1'b1;
            end else if (grant_d) begin
               state_d = SERVE_D;
               addr_d  = d_address;
               wdata_d = d_wdata;
               rd_d    = ~d_write;
               wr_d    = d_write;
               busy_d  = 1'b1;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               state_d = DONE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         DONE: begin
            // Recovery cycle so the finished requester can drop its request before the next sample.
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         last_d_q <= last_d_d;
      end
   end

   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign arb_busy     = busy_q;

   // Completion is forwarded combinationally; reset clears state_q at once, so no resp escapes.
   assign i_resp  = (state_q == SERVE_I) & pmem_resp;
   assign d_resp  = (state_q == SERVE_D) & pmem_resp;
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed and randomized checking of mem_arbiter against a cycle-count model of the arbitration rules.
// Latency : n/a (testbench).
// Backpressure: the bench plays both caches (hold until resp) and a random-latency memory.
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_read, d_read, d_write, pmem_resp;
   logic [15:0]  i_address, d_address;
   logic [127:0] d_wdata, pmem_rdata;
   logic [127:0] i_rdata, d_rdata, pmem_wdata;
   logic [15:0]  pmem_address;
   logic         i_resp, d_resp, pmem_read, pmem_write, arb_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .arb_busy(arb_busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic all_zero(input string tag);
      chk1({tag, "_rd"}, pmem_read, 1'b0);
      chk1({tag, "_wr"}, pmem_write, 1'b0);
      chk1({tag, "_iresp"}, i_resp, 1'b0);
      chk1({tag, "_dresp"}, d_resp, 1'b0);
      chk1({tag, "_busy"}, arb_busy, 1'b0);
      chk16({tag, "_addr"}, pmem_address, 16'h0);
      chkw({tag, "_wdata"}, pmem_wdata, 128'h0);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
   endtask

   // Called in an IDLE cycle with the request(s) already driven. Expects the grant at the next
   // edge, lat+1 strobe cycles, resp on the last one, then DONE and back to IDLE.
   task automatic run_txn(input bit is_d, input logic [15:0] a, input bit wr,
                          input logic [127:0] wd, input int lat, input logic [127:0] rd,
                          input bit chg);
      cyc();
      for (int j = 0; j <= lat; j++) begin
         if (j > 0) cyc();
         chk1("txn_rd", pmem_read, !wr);
         chk1("txn_wr", pmem_write, wr);
         chk16("txn_addr", pmem_address, a);
         if (wr) chkw("txn_wdata", pmem_wdata, wd);
         chk1("txn_busy", arb_busy, 1'b1);
         if (chg && j == 0) begin
            d_address = 16'h5000;
            d_wdata   = ~d_wdata;
         end
         if (j == lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
         end
         #1;
         chk1("txn_iresp", i_resp, (j == lat) && !is_d);
         chk1("txn_dresp", d_resp, (j == lat) && is_d);
         if (j == lat) begin
            if (is_d) begin
               chkw("txn_drdata", d_rdata, rd);
               d_read = 1'b0; d_write = 1'b0;
            end else begin
               chkw("txn_irdata", i_rdata, rd);
               i_read = 1'b0;
            end
         end
      end
      cyc();
      pmem_resp = 1'b0;
      chk1("done_rd", pmem_read, 1'b0);
      chk1("done_wr", pmem_write, 1'b0);
      chk1("done_resp", i_resp | d_resp, 1'b0);
      chk1("done_busy", arb_busy, 1'b1);
      cyc();
      chk1("idle_busy", arb_busy, 1'b0);
      chk1("idle_strobe", pmem_read | pmem_write, 1'b0);
   endtask

   // Reference model state for the random phase.
   bit           m_busy, m_port, m_wr, m_last_d, pend_i, pend_d, just_i, just_d, serving;
   bit           exp_i, exp_d;
   int           m_start, m_done_cyc, m_idle_at, k;
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;

   initial begin
      reset = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
      #2;
      all_zero("reset");
      repeat (3) cyc();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         all_zero("idle");
      end

      // Single icache read, memory answers on the third strobe cycle.
      i_read = 1'b1; i_address = 16'h1230;
      run_txn(1'b0, 16'h1230, 1'b0, 128'h0, 2, {16{8'hA5}}, 1'b0);

      // Dcache write-back.
      d_write = 1'b1; d_address = 16'h4000; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      run_txn(1'b1, 16'h4000, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1, 128'h0, 1'b0);

      // Contention straight out of reset: D first, then I, then alternation.
      reset_dut();
      i_read = 1'b1; i_address = 16'h1111;
      d_read = 1'b1; d_address = 16'h2222;
      run_txn(1'b1, 16'h2222, 1'b0, 128'h0, 1, 128'h22, 1'b0);
      run_txn(1'b0, 16'h1111, 1'b0, 128'h0, 0, 128'h11, 1'b0);
      i_read = 1'b1; i_address = 16'h3333;
      d_read = 1'b1; d_write = 1'b1; d_address = 16'h4444; d_wdata = 128'hFEED;
      run_txn(1'b0, 16'h3333, 1'b0, 128'h0, 1, 128'h33, 1'b0);
      run_txn(1'b1, 16'h4444, 1'b1, 128'hFEED, 2, 128'h44, 1'b0);

      // Requester inputs change after grant; registered values must hold.
      d_read = 1'b1; d_address = 16'h4000; d_wdata = 128'h0;
      run_txn(1'b1, 16'h4000, 1'b0, 128'h0, 3, 128'hBEEF, 1'b1);

      // Reset during SERVE_I: strobe drops at once, no resp, fresh grant afterwards.
      reset_dut();
      i_read = 1'b1; i_address = 16'h0ABC;
      cyc();
      cyc();
      chk1("mid_rd_before", pmem_read, 1'b1);
      reset = 1'b1;
      pmem_resp = 1'b1;
      #1;
      all_zero("midrst");
      cyc();
      cyc();
      pmem_resp = 1'b0;
      reset = 1'b0;
      run_txn(1'b0, 16'h0ABC, 1'b0, 128'h0, 1, 128'h5A5A, 1'b0);

      // Randomized phase.
      reset_dut();
      m_busy = 0; m_last_d = 0; pend_i = 0; pend_d = 0;
      m_start = 0; m_done_cyc = -10; m_idle_at = 0;
      m_port = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      for (int n = 0; n < 3000; n++) begin
         cyc();
         just_i = 0; just_d = 0;
         serving = m_busy && (n >= m_start);
         chk1("rnd_rd", pmem_read, serving && !m_wr);
         chk1("rnd_wr", pmem_write, serving && m_wr);
         chk1("rnd_busy", arb_busy, serving || (n == m_done_cyc));
         if (serving) begin
            chk16("rnd_addr", pmem_address, m_addr);
            if (m_wr) chkw("rnd_wdata", pmem_wdata, m_wdata);
         end
         pmem_resp  = serving ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
         pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
         #1;
         exp_i = serving && pmem_resp && !m_port;
         exp_d = serving && pmem_resp && m_port;
         chk1("rnd_iresp", i_resp, exp_i);
         chk1("rnd_dresp", d_resp, exp_d);
         if (exp_i) chkw("rnd_irdata", i_rdata, pmem_rdata);
         if (exp_d) chkw("rnd_drdata", d_rdata, pmem_rdata);

         if (serving && pmem_resp) begin
            m_busy = 0;
            m_done_cyc = n + 1;
            m_idle_at = n + 2;
            if (m_port) begin
               d_read = 1'b0; d_write = 1'b0; pend_d = 0; just_d = 1;
            end else begin
               i_read = 1'b0; pend_i = 0; just_i = 1;
            end
         end else if (serving && $urandom_range(0, 3) == 0) begin
            if (m_port) begin
               d_address = 16'($urandom);
               d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               i_address = 16'($urandom);
            end
         end

         if (!pend_i && !just_i && $urandom_range(0, 3) == 0) begin
            i_read = 1'b1; i_address = 16'($urandom); pend_i = 1;
         end
         if (!pend_d && !just_d && $urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 2);
            d_read  = (k != 1);
            d_write = (k != 0);
            d_address = 16'($urandom);
            d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            pend_d = 1;
         end

         if (!m_busy && n >= m_idle_at && (pend_i || pend_d)) begin
            if (pend_i && pend_d) begin
               m_port   = !m_last_d;
               m_last_d = m_port;
            end else begin
               m_port = pend_d;
            end
            m_addr  = m_port ? d_address : i_address;
            m_wr    = m_port && d_write;
            m_wdata = d_wdata;
            m_busy  = 1;
            m_start = n + 1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
